// File: rtl/ide_pio_pkg.sv
// Shared types and PIO timing table for the Gayle IDE PIO strobe sequencer.
package ide_pio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StActive,
    StAck,
    StRecover
  } state_e;

  typedef logic [1:0] mode_t;

  typedef struct packed {
    logic [2:0] setup;
    logic [2:0] active;
    logic [2:0] recover;
  } timing_t;

  // Phase lengths in CLKCPU cycles, indexed by PIO mode; every entry is >= 1.
  localparam timing_t TimingTable [4] = '{
    '{setup: 3'd3, active: 3'd6, recover: 3'd7},
    '{setup: 3'd2, active: 3'd5, recover: 3'd4},
    '{setup: 3'd1, active: 3'd4, recover: 3'd2},
    '{setup: 3'd1, active: 3'd3, recover: 3'd1}
  };

  // A phase of N cycles ends on the edge where the counter, loaded with N-1, reads zero.
  function automatic logic [2:0] load_val(logic [2:0] cycles);
    return cycles - 3'd1;
  endfunction

endpackage

// File: rtl/ide_pio_seq_if.sv
// CPU-side bus request and IDE strobe signals of the PIO sequencer.
interface ide_pio_seq_if;
  logic AS20;
  logic RW20;
  logic IDE_SEL;
  logic IOR;
  logic IOW;
  logic IDE_ACK;

  modport master (
    output AS20, RW20, IDE_SEL,
    input  IOR, IOW, IDE_ACK
  );

  modport slave (
    input  AS20, RW20, IDE_SEL,
    output IOR, IOW, IDE_ACK
  );
endinterface

// File: rtl/ide_pio_cnt.sv
// Loadable 3-bit down-counter with zero flag; holds at zero, load wins over decrement.
module ide_pio_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ide_pio_seq.sv
// IDE PIO cycle sequencer: times SETUP/ACTIVE/RECOVER phases around IOR/IOW and
// requests DSACK via IDE_ACK once the active phase has elapsed.
module ide_pio_seq
  import ide_pio_pkg::*;
#(
  parameter mode_t DEF_MODE = 2'd0
) (
  input  logic         CLKCPU,
  input  logic         RESET,
  ide_pio_seq_if.slave bus_io,
  input  mode_t        MODE,
  input  logic         MODE_OVR,
  output logic         BUSY
);

  state_e     state_q, state_d;
  logic       ior_q, ior_d;
  logic       iow_q, iow_d;
  logic       ack_q, ack_d;
  logic       wr_q, wr_d;
  logic       served_q, served_d;
  mode_t      mode_q, mode_d;
  mode_t      mode_eff;
  logic       req;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [2:0] cnt_val;

  assign mode_eff = MODE_OVR ? DEF_MODE : MODE;
  // Served flag blocks re-entry for a bus cycle that was already acknowledged.
  assign req      = !bus_io.AS20 && !bus_io.IDE_SEL && !served_q;

  always_comb begin
    state_d  = state_q;
    ior_d    = ior_q;
    iow_d    = iow_q;
    ack_d    = ack_q;
    wr_d     = wr_q;
    mode_d   = mode_q;
    served_d = bus_io.AS20 ? 1'b0 : served_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = 3'd0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          mode_d   = mode_eff;
          wr_d     = ~bus_io.RW20;
          cnt_load = 1'b1;
          cnt_val  = load_val(TimingTable[mode_eff].setup);
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (bus_io.AS20) begin
          cnt_load = 1'b1;
          cnt_val  = load_val(TimingTable[mode_q].recover);
          state_d  = StRecover;
        end else if (cnt_zero) begin
          ior_d    = wr_q;
          iow_d    = ~wr_q;
          cnt_load = 1'b1;
          cnt_val  = load_val(TimingTable[mode_q].active);
          state_d  = StActive;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StActive: begin
        if (bus_io.AS20) begin
          ior_d    = 1'b1;
          iow_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = load_val(TimingTable[mode_q].recover);
          state_d  = StRecover;
        end else if (cnt_zero) begin
          ack_d    = 1'b0;
          served_d = 1'b1;
          state_d  = StAck;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StAck: begin
        if (bus_io.AS20) begin
          ior_d    = 1'b1;
          iow_d    = 1'b1;
          ack_d    = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = load_val(TimingTable[mode_q].recover);
          state_d  = StRecover;
        end
      end
      StRecover: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q  <= StIdle;
      ior_q    <= 1'b1;
      iow_q    <= 1'b1;
      ack_q    <= 1'b1;
      wr_q     <= 1'b0;
      mode_q   <= 2'd0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ior_q    <= ior_d;
      iow_q    <= iow_d;
      ack_q    <= ack_d;
      wr_q     <= wr_d;
      mode_q   <= mode_d;
      served_q <= served_d;
    end
  end

  ide_pio_cnt u_cnt (
    .clk_i      (CLKCPU),
    .rst_ni     (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign bus_io.IOR     = ior_q;
  assign bus_io.IOW     = iow_q;
  assign bus_io.IDE_ACK = ack_q;
  assign BUSY           = (state_q != StIdle);

endmodule

// File: tb/tb_ide_pio_seq.sv
// Scoreboard bench: stimulus queues expected output transitions {IOR,IOW,IDE_ACK,BUSY}
// with their edge numbers; the monitor pops one per observed transition.
module tb_ide_pio_seq;
  import ide_pio_pkg::*;

  logic  CLKCPU = 1'b0;
  logic  RESET  = 1'b0;
  mode_t MODE;
  logic  MODE_OVR;
  logic  BUSY;

  ide_pio_seq_if bus ();

  ide_pio_seq #(
    .DEF_MODE (2'd2)
  ) dut (
    .CLKCPU   (CLKCPU),
    .RESET    (RESET),
    .bus_io   (bus),
    .MODE     (MODE),
    .MODE_OVR (MODE_OVR),
    .BUSY     (BUSY)
  );

  always #5 CLKCPU = ~CLKCPU;

  int edge_n = 0;
  always @(posedge CLKCPU) edge_n <= edge_n + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         mon_en   = 1'b0;
  logic [3:0] prev;
  string      test_name = "reset";

  always @(negedge CLKCPU) begin : monitor
    logic [3:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = {bus.IOR, bus.IOW, bus.IDE_ACK, BUSY};
      checks++;
      if (!bus.IOR && !bus.IOW) begin
        failures++;
        $display("FAIL %s strobe_overlap edge=%0d got IOR=%b IOW=%b required not both low",
                 test_name, edge_n, bus.IOR, bus.IOW);
      end
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s unexpected_change edge=%0d got=%b required no change (was %b)",
                   test_name, edge_n, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != edge_n || e.val !== cur) begin
            failures++;
            $display("FAIL %s transition got edge=%0d val=%b required edge=%0d val=%b",
                     test_name, edge_n, cur, e.cyc, e.val);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic expect_ev(input int cyc, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Advance to the negedge just before posedge number e.
  task automatic go(input int e);
    while (edge_n + 1 < e) @(negedge CLKCPU);
  endtask

  task automatic end_test(input int e);
    go(e);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_transitions got pending=%0d required 0 (next edge=%0d val=%b)",
               test_name, exp_q.size(), exp_q[0].cyc, exp_q[0].val);
      exp_q.delete();
    end
  endtask

  task automatic release_bus();
    bus.AS20    = 1'b1;
    bus.IDE_SEL = 1'b1;
  endtask

  task automatic request(input logic rw, input mode_t m, input logic ovr);
    bus.AS20    = 1'b0;
    bus.IDE_SEL = 1'b0;
    bus.RW20    = rw;
    MODE        = m;
    MODE_OVR    = ovr;
  endtask

  initial begin
    int b;
    bus.AS20    = 1'b1;
    bus.RW20    = 1'b1;
    bus.IDE_SEL = 1'b1;
    MODE        = 2'd0;
    MODE_OVR    = 1'b0;
    repeat (3) @(negedge CLKCPU);
    checks++;
    if ({bus.IOR, bus.IOW, bus.IDE_ACK, BUSY} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_state got=%b required=1110",
               {bus.IOR, bus.IOW, bus.IDE_ACK, BUSY});
    end
    prev   = 4'b1110;
    mon_en = 1'b1;
    RESET  = 1'b1;

    // Mode0 read, accepted on the first edge out of reset; late input changes ignored.
    test_name = "mode0_read";
    b = edge_n + 1;
    request(1'b1, 2'd0, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 3, 4'b0111);
    expect_ev(b + 9, 4'b0101);
    expect_ev(b + 12, 4'b1111);
    expect_ev(b + 19, 4'b1110);
    go(b + 1);
    bus.RW20 = 1'b0;
    MODE     = 2'd3;
    MODE_OVR = 1'b1;
    go(b + 12);
    release_bus();
    MODE_OVR = 1'b0;
    end_test(b + 22);

    test_name = "mode3_write";
    b = edge_n + 1;
    request(1'b0, 2'd3, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 1, 4'b1011);
    expect_ev(b + 4, 4'b1001);
    expect_ev(b + 6, 4'b1111);
    expect_ev(b + 7, 4'b1110);
    go(b + 6);
    release_bus();
    end_test(b + 10);

    test_name = "mode_override";
    b = edge_n + 1;
    request(1'b1, 2'd0, 1'b1);
    expect_ev(b, 4'b1111);
    expect_ev(b + 1, 4'b0111);
    expect_ev(b + 5, 4'b0101);
    expect_ev(b + 7, 4'b1111);
    expect_ev(b + 9, 4'b1110);
    go(b + 2);
    MODE_OVR = 1'b0;
    go(b + 7);
    release_bus();
    end_test(b + 12);

    test_name = "abort_mode1";
    b = edge_n + 1;
    request(1'b1, 2'd1, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 2, 4'b0111);
    expect_ev(b + 3, 4'b1111);
    expect_ev(b + 7, 4'b1110);
    go(b + 3);
    release_bus();
    end_test(b + 10);

    test_name = "reset_midcycle";
    b = edge_n + 1;
    request(1'b1, 2'd0, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 3, 4'b0111);
    expect_ev(b + 4, 4'b1110);
    expect_ev(b + 5, 4'b1111);
    expect_ev(b + 8, 4'b0111);
    expect_ev(b + 14, 4'b0101);
    expect_ev(b + 15, 4'b1111);
    expect_ev(b + 22, 4'b1110);
    go(b + 4);
    RESET = 1'b0;
    go(b + 5);
    RESET = 1'b1;
    go(b + 15);
    release_bus();
    end_test(b + 25);

    test_name = "long_hold";
    b = edge_n + 1;
    request(1'b1, 2'd2, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 1, 4'b0111);
    expect_ev(b + 5, 4'b0101);
    expect_ev(b + 35, 4'b1111);
    expect_ev(b + 37, 4'b1110);
    go(b + 35);
    release_bus();
    end_test(b + 40);

    test_name = "mode1_write";
    b = edge_n + 1;
    request(1'b0, 2'd1, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 2, 4'b1011);
    expect_ev(b + 7, 4'b1001);
    expect_ev(b + 8, 4'b1111);
    expect_ev(b + 12, 4'b1110);
    go(b + 8);
    release_bus();
    end_test(b + 15);

    // A new request arriving during RECOVER waits until IDLE.
    test_name = "back_to_back";
    b = edge_n + 1;
    request(1'b1, 2'd3, 1'b0);
    expect_ev(b, 4'b1111);
    expect_ev(b + 1, 4'b0111);
    expect_ev(b + 4, 4'b0101);
    expect_ev(b + 6, 4'b1111);
    expect_ev(b + 7, 4'b1110);
    expect_ev(b + 8, 4'b1111);
    expect_ev(b + 9, 4'b0111);
    expect_ev(b + 12, 4'b0101);
    expect_ev(b + 13, 4'b1111);
    expect_ev(b + 14, 4'b1110);
    go(b + 6);
    release_bus();
    go(b + 7);
    request(1'b1, 2'd3, 1'b0);
    go(b + 13);
    release_bus();
    end_test(b + 17);

    test_name = "no_select";
    b = edge_n + 1;
    bus.AS20    = 1'b0;
    bus.IDE_SEL = 1'b1;
    go(b + 6);
    release_bus();
    end_test(b + 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
